instruction_loader: RTL and testbench



---
 rtl/instruction_loader_pkg.sv | 21 ++
 rtl/instruction_loader_timeout.sv | 38 +++
 rtl/instruction_loader.sv | 153 +++++++++++++++
 tb/tb_instruction_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader (package loader_pkg).
package loader_pkg;

    localparam logic [7:0] LOADER_SYNC_DEFAULT = 8'hA5;
    localparam int         IMEM_WORDS          = 256;
    localparam int         IMEM_IDX_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    function automatic logic [31:0] idx_to_addr(input logic [IMEM_IDX_W-1:0] idx);
        return {22'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_loader_timeout.sv
// Inter-byte idle counter for the loader; expired is constant 0 when TIMEOUT_CYCLES is 0.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            // Count saturates one below the limit; the edge that would reach it is the expiry.
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (clear || !enable) begin
                    count <= '0;
                end else if (count != LAST) begin
                    count <= count + CW'(1);
                end
            end

            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/instruction_loader.sv
// Framed UART program loader writing 32-bit big-endian words into instruction RAM.
// Optional checksum byte and CHECK state enabled by INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int unsigned BASE_WORD      = 0,
    parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int                    CNT_W    = IMEM_IDX_W + 1;
    localparam logic [IMEM_IDX_W-1:0] BASE_IDX = IMEM_IDX_W'(BASE_WORD % IMEM_WORDS);

    loader_state_t         state;
    logic [CNT_W-1:0]      word_total;
    logic [CNT_W-1:0]      word_cnt;
    logic [IMEM_IDX_W-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           word_sr;
    logic [31:0]           word_next;
    logic                  last_word;
    logic                  to_enable;
    logic                  to_expired;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign word_next = {word_sr[23:0], rx_data};
    assign last_word = (word_cnt + CNT_W'(1)) == word_total;
    assign to_enable = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (to_enable),
        .expired(to_expired)
    );

    // Byte assembly register: pure data, never needs a reset value.
    always_ff @(posedge clk) begin
        if (rx_valid && state == ST_DATA) begin
            word_sr <= word_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_total <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            lane       <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state      <= ST_COUNT;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (rx_valid) begin
                        word_total <= (rx_data == 8'd0) ? CNT_W'(IMEM_WORDS) : CNT_W'(rx_data);
                        word_idx   <= BASE_IDX;
                        word_cnt   <= '0;
                        lane       <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                        state      <= ST_DATA;
                    end else if (to_expired) begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= idx_to_addr(word_idx);
                            imem_wdata <= word_next;
                            word_idx   <= word_idx + IMEM_IDX_W'(1);
                            word_cnt   <= word_cnt + CNT_W'(1);
                            if (last_word) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                                state     <= ST_CHECK;
`else
                                state     <= ST_DONE;
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
`endif
                            end
                        end
                    end else if (to_expired) begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                    end
                end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state     <= ST_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end else if (to_expired) begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader; follows INSTRUCTION_LOADER_CHECKSUM_EN if defined.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        we0, hold0, done0, err0;
    logic [31:0] addr0, wdata0;
    logic        we1, hold1, done1, err1;
    logic [31:0] addr1, wdata1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] q0a[$], q0d[$], q1a[$], q1d[$];
    logic [7:0]  bq[$];

    always #5 clk = ~clk;

    instruction_loader #(
        .BASE_WORD(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)
    ) u_dut0 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .cpu_hold(hold0), .load_done(done0), .load_error(err0)
    );

    instruction_loader #(
        .BASE_WORD(250), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .cpu_hold(hold1), .load_done(done1), .load_error(err1)
    );

    always @(negedge clk) begin
        if (we0) begin
            q0a.push_back(addr0);
            q0d.push_back(wdata0);
        end
        if (we1) begin
            q1a.push_back(addr1);
            q1d.push_back(wdata1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[i]) put(b[i]);
    endtask

    task automatic send_cs(input logic [7:0] cs);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        put(cs);
`else
        if (cs == 8'h00) rx_data = 8'h00;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk("rst_we",   {31'b0, we0},   32'd0);
        chk("rst_addr", addr0,          32'd0);
        chk("rst_data", wdata0,         32'd0);
        chk("rst_hold", {31'b0, hold0}, 32'd0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        chk("rst_err",  {31'b0, err0},  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic frame
        bq = {8'hA5, 8'h02, 8'h20, 8'h04, 8'h00};
        send(bq);
        put(8'h03);
        chk("t1_we0",   {31'b0, we0}, 32'd1);
        chk("t1_addr0", addr0, 32'h0000_0000);
        chk("t1_data0", wdata0, 32'h2004_0003);
        put(8'h0C);
        chk("t1_we_pulse", {31'b0, we0}, 32'd0);
        bq = {8'h00, 8'h00};
        send(bq);
        put(8'h05);
        chk("t1_we1",   {31'b0, we0}, 32'd1);
        chk("t1_addr1", addr0, 32'h0000_0004);
        chk("t1_data1", wdata0, 32'h0C00_0005);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        chk("t1_hold_pre", {31'b0, hold0}, 32'd1);
        put(8'h2E);
`endif
        chk("t1_done", {31'b0, done0}, 32'd1);
        chk("t1_hold", {31'b0, hold0}, 32'd0);
        put(8'h33);
        chk("t1_done_ignore", {31'b0, done0}, 32'd1);
        idle(2);
        chk("t1_nwrites", q0a.size(), 32'd2);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        // Bad checksum
        do_reset();
        bq = {8'hA5, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h05, 8'hFF};
        send(bq);
        chk("t2_err",  {31'b0, err0},  32'd1);
        chk("t2_hold", {31'b0, hold0}, 32'd1);
        chk("t2_done", {31'b0, done0}, 32'd0);
        idle(1);
        chk("t2_nwrites", q0a.size(), 32'd2);
        put(8'hA5);
        chk("t2_err_clr", {31'b0, err0}, 32'd0);
`endif

        // Full-size frame on the BASE_WORD=250 instance
        do_reset();
        cs = 8'h00;
        bq = {8'hA5, 8'h00};
        for (int k = 0; k < 256; k++) begin
            w = {8'(k), 8'h5A, 8'(255 - k), 8'h3C};
            bq.push_back(w[31:24]); bq.push_back(w[23:16]);
            bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        send(bq);
        send_cs(cs);
        chk("t3_done", {31'b0, done1}, 32'd1);
        idle(2);
        chk("t3_nwrites", q1a.size(), 32'd256);
        if (q1a.size() == 256) begin
            chk("t3_first_addr", q1a[0], 32'h3E8);
            chk("t3_wrap_addr",  q1a[6], 32'h000);
            chk("t3_last_addr",  q1a[255], 32'h3E4);
            for (int k = 0; k < 256; k++) begin
                chk("t3_addr", q1a[k], ((250 + k) % 256) * 4);
                chk("t3_data", q1d[k], {8'(k), 8'h5A, 8'(255 - k), 8'h3C});
            end
        end

        // Timeout after silence, clear by sync, then a byte on the expiry cycle
        do_reset();
        bq = {8'hA5, 8'h01, 8'h20};
        send(bq);
        idle(99);
        chk("t4_err_early", {31'b0, err0}, 32'd0);
        idle(1);
        chk("t4_err",  {31'b0, err0},  32'd1);
        chk("t4_hold", {31'b0, hold0}, 32'd1);
        put(8'h77);
        chk("t4_err_ignore", {31'b0, err0}, 32'd1);
        put(8'hA5);
        chk("t4_err_clr", {31'b0, err0}, 32'd0);
        bq = {8'h01, 8'h20};
        send(bq);
        idle(99);
        put(8'h11);
        chk("t4_byte_wins", {31'b0, err0}, 32'd0);
        idle(3);
        chk("t4_still_ok", {31'b0, err0}, 32'd0);
        bq = {8'h22, 8'h33};
        send(bq);
        send_cs(8'h20);
        chk("t4_done", {31'b0, done0}, 32'd1);
        idle(2);
        chk("t4_nwrites", q0a.size(), 32'd1);
        if (q0d.size() > 0) chk("t4_data", q0d[0], 32'h2011_2233);

        // Reset mid-frame
        do_reset();
        bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(bq);
        chk("t5_hold_pre", {31'b0, hold0}, 32'd1);
        chk("t5_data_pre", wdata0, 32'h1122_3344);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_we",    {31'b0, we0},   32'd0);
        chk("t5_addr",  addr0,          32'd0);
        chk("t5_data",  wdata0,         32'd0);
        chk("t5_hold",  {31'b0, hold0}, 32'd0);
        chk("t5_done",  {31'b0, done0}, 32'd0);
        chk("t5_err",   {31'b0, err0},  32'd0);
        chk("t5_addr1", addr1,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
        bq = {8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(bq);
        send_cs(8'h22);
        chk("t5_reload_done", {31'b0, done0}, 32'd1);
        idle(2);
        chk("t5_nwrites", q0a.size(), 32'd1);
        if (q0a.size() > 0) begin
            chk("t5_reload_addr", q0a[0], 32'h0);
            chk("t5_reload_data", q0d[0], 32'hDEAD_BEEF);
        end

        // Back-to-back bytes with sync value inside the data
        do_reset();
        bq = {8'hA5, 8'h02, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hA5, 8'h06};
        send(bq);
        send_cs(8'hA7);
        chk("t6_done", {31'b0, done0}, 32'd1);
        chk("t6_err",  {31'b0, err0},  32'd0);
        idle(2);
        chk("t6_nwrites", q0a.size(), 32'd2);
        if (q0a.size() == 2) begin
            chk("t6_addr0", q0a[0], 32'h0);
            chk("t6_data0", q0d[0], 32'hA501_0203);
            chk("t6_addr1", q0a[1], 32'h4);
            chk("t6_data1", q0d[1], 32'h04A5_A506);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
